// File: rtl/voice_allocator_pkg.sv
// Shared encodings for the voice allocator: FSM states, slot states and
// candidate priority classes used while scanning the voice pool.
package voice_allocator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_GAP    = 2'd3
    } fsm_t;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_ACTIVE    = 2'd1,
        SLOT_RELEASING = 2'd2
    } slot_t;

    // Lower value wins. CLS_MATCH doubles as the note-off hit class.
    typedef enum logic [2:0] {
        CLS_MATCH = 3'd0,
        CLS_FREE  = 3'd1,
        CLS_REL   = 3'd2,
        CLS_ACT   = 3'd3,
        CLS_NONE  = 3'd4
    } cls_t;

    function automatic logic cls_better(input cls_t c, input cls_t cand, input logic older);
        return (c < cand) || ((c == cand) && ((c == CLS_REL) || (c == CLS_ACT)) && older);
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Event handshake from the sequencer plus the per-voice control bus.
// slave = allocator side, master = event source / voice array side.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7,
    parameter int FREQ_BITS  = 16
);
    logic                            ev_valid;
    logic                            ev_ready;
    logic                            ev_note_on;
    logic [NOTE_BITS-1:0]            ev_note;
    logic [FREQ_BITS-1:0]            ev_freq;
    logic [NUM_VOICES-1:0]           voice_gate;
    logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq;
    logic [NUM_VOICES-1:0]           voice_busy;
    logic                            steal_pulse;

    modport master (
        output ev_valid, ev_note_on, ev_note, ev_freq,
        input  ev_ready, voice_gate, voice_freq, voice_busy, steal_pulse
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_note, ev_freq,
        output ev_ready, voice_gate, voice_freq, voice_busy, steal_pulse
    );
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice slot: state, note, freq, gate, saturating age and release timer.
// Latency: strobes take effect on the next edge.
// Backpressure: none, strobes are always accepted.
module voice_allocator_slot
    import voice_allocator_pkg::*;
#(
    parameter int NOTE_BITS    = 7,
    parameter int FREQ_BITS    = 16,
    parameter int AGE_BITS     = 8,
    parameter int RELEASE_BITS = 20,
    parameter int RELEASE_HOLD = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 assign_en,
    input  logic                 assign_gate,
    input  logic [NOTE_BITS-1:0] assign_note,
    input  logic [FREQ_BITS-1:0] assign_freq,
    input  logic                 gate_on,
    input  logic                 gate_off,
    input  logic                 age_inc,
    output slot_t                state,
    output logic [NOTE_BITS-1:0] note,
    output logic [FREQ_BITS-1:0] freq,
    output logic                 gate,
    output logic [AGE_BITS-1:0]  age
);

    localparam logic [RELEASE_BITS-1:0] HOLD = RELEASE_BITS'(RELEASE_HOLD);

    logic [RELEASE_BITS-1:0] rel_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SLOT_FREE;
            note      <= '0;
            freq      <= '0;
            gate      <= 1'b0;
            age       <= '0;
            rel_timer <= '0;
        end else if (assign_en) begin
            // Assignment wins over a release expiring on the same edge.
            state     <= SLOT_ACTIVE;
            note      <= assign_note;
            freq      <= assign_freq;
            gate      <= assign_gate;
            age       <= '0;
            rel_timer <= '0;
        end else if (gate_off) begin
            state     <= SLOT_RELEASING;
            gate      <= 1'b0;
            rel_timer <= HOLD;
        end else begin
            if (gate_on) begin
                gate <= 1'b1;
            end
            if (age_inc && (state != SLOT_FREE) && (age != '1)) begin
                age <= age + 1'b1;
            end
            if (state == SLOT_RELEASING) begin
                if (rel_timer <= RELEASE_BITS'(1)) begin
                    state     <= SLOT_FREE;
                    rel_timer <= '0;
                end else begin
                    rel_timer <= rel_timer - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note events to a pool of voice slots, stealing when full.
// Latency: accept at e0, one slot scanned per edge, outputs update at e(NUM_VOICES+1) (+RETRIG_GAP on retrigger).
// Backpressure: ev_ready only in IDLE; one event in flight at a time.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int FREQ_BITS    = 16,
    parameter int NOTE_BITS    = 7,
    parameter int AGE_BITS     = 8,
    parameter int RELEASE_BITS = 20,
    parameter int RELEASE_HOLD = 1000000,
    parameter int RETRIG_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    voice_allocator_if.slave bus
);

    localparam int IDX_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int GAP_BITS = $clog2(RETRIG_GAP + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

    fsm_t                 state;
    logic [IDX_BITS-1:0]  scan_idx;
    logic [IDX_BITS-1:0]  cand_idx;
    cls_t                 cand_cls;
    logic [AGE_BITS-1:0]  cand_age;
    logic                 ev_on_q;
    logic [NOTE_BITS-1:0] ev_note_q;
    logic [FREQ_BITS-1:0] ev_freq_q;
    logic [GAP_BITS-1:0]  gap_cnt;
    logic                 steal_q;

    slot_t                slot_state [NUM_VOICES];
    logic [NOTE_BITS-1:0] slot_note  [NUM_VOICES];
    logic [FREQ_BITS-1:0] slot_freq  [NUM_VOICES];
    logic                 slot_gate  [NUM_VOICES];
    logic [AGE_BITS-1:0]  slot_age   [NUM_VOICES];

    logic  commit_on, commit_off, gap_done, assign_gate;
    slot_t sc_state;
    logic [AGE_BITS-1:0] sc_age;
    cls_t  scan_cls;

    assign commit_on   = (state == ST_COMMIT) && ev_on_q;
    assign commit_off  = (state == ST_COMMIT) && !ev_on_q && (cand_cls == CLS_MATCH);
    assign gap_done    = (state == ST_GAP) && (gap_cnt == GAP_BITS'(1));
    assign assign_gate = !slot_gate[cand_idx];

    // Classify the slot under the scan pointer against the latched event.
    always_comb begin
        sc_state = slot_state[scan_idx];
        sc_age   = slot_age[scan_idx];
        scan_cls = CLS_NONE;
        if (ev_on_q) begin
            if ((sc_state != SLOT_FREE) && (slot_note[scan_idx] == ev_note_q)) scan_cls = CLS_MATCH;
            else if (sc_state == SLOT_FREE)                                    scan_cls = CLS_FREE;
            else if (sc_state == SLOT_RELEASING)                               scan_cls = CLS_REL;
            else                                                               scan_cls = CLS_ACT;
        end else if ((sc_state == SLOT_ACTIVE) && (slot_note[scan_idx] == ev_note_q)) begin
            scan_cls = CLS_MATCH;
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        logic sel;
        assign sel = (cand_idx == IDX_BITS'(i));

        voice_allocator_slot #(
            .NOTE_BITS    (NOTE_BITS),
            .FREQ_BITS    (FREQ_BITS),
            .AGE_BITS     (AGE_BITS),
            .RELEASE_BITS (RELEASE_BITS),
            .RELEASE_HOLD (RELEASE_HOLD)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .assign_en   (commit_on && sel),
            .assign_gate (assign_gate),
            .assign_note (ev_note_q),
            .assign_freq (ev_freq_q),
            .gate_on     (gap_done && sel),
            .gate_off    (commit_off && sel),
            .age_inc     (commit_on && !sel),
            .state       (slot_state[i]),
            .note        (slot_note[i]),
            .freq        (slot_freq[i]),
            .gate        (slot_gate[i]),
            .age         (slot_age[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            scan_idx  <= '0;
            cand_idx  <= '0;
            cand_cls  <= CLS_NONE;
            cand_age  <= '0;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_freq_q <= '0;
            gap_cnt   <= '0;
            steal_q   <= 1'b0;
        end else begin
            steal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ev_valid) begin
                        ev_on_q   <= bus.ev_note_on;
                        ev_note_q <= bus.ev_note;
                        ev_freq_q <= bus.ev_freq;
                        scan_idx  <= '0;
                        cand_idx  <= '0;
                        cand_cls  <= CLS_NONE;
                        cand_age  <= '0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on equal class and age.
                    if (cls_better(scan_cls, cand_cls, sc_age > cand_age)) begin
                        cand_cls <= scan_cls;
                        cand_idx <= scan_idx;
                        cand_age <= sc_age;
                    end
                    if (scan_idx == LAST_IDX) state <= ST_COMMIT;
                    else                      scan_idx <= scan_idx + 1'b1;
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (ev_on_q) begin
                        steal_q <= (slot_state[cand_idx] != SLOT_FREE) &&
                                   (slot_note[cand_idx] != ev_note_q);
                        if (slot_gate[cand_idx]) begin
                            gap_cnt <= GAP_BITS'(RETRIG_GAP);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_BITS'(1)) state <= ST_IDLE;
                    else                         gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ev_ready    = (state == ST_IDLE) && !rst;
    assign bus.steal_pulse = steal_q;

    always_comb begin
        bus.voice_gate = '0;
        bus.voice_busy = '0;
        bus.voice_freq = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            bus.voice_gate[i]                      = slot_gate[i];
            bus.voice_busy[i]                      = (slot_state[i] != SLOT_FREE);
            bus.voice_freq[i*FREQ_BITS +: FREQ_BITS] = slot_freq[i];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int NV   = 4;
    localparam int FB   = 16;
    localparam int NB   = 7;
    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_BITS(NB), .FREQ_BITS(FB)) bus ();

    voice_allocator #(
        .NUM_VOICES(NV), .FREQ_BITS(FB), .NOTE_BITS(NB), .AGE_BITS(8),
        .RELEASE_BITS(20), .RELEASE_HOLD(HOLD), .RETRIG_GAP(GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 free, 1 active, 2 releasing; time in clock edges.
    int          cyc;
    int          m_state   [NV];
    int          m_note    [NV];
    logic [FB-1:0] m_freq  [NV];
    int          m_age     [NV];
    bit          m_gate    [NV];
    int          m_free_at [NV];
    bit          m_ready, m_rdy_prev, m_steal, pend, pend_on;
    int          pend_note, commit_at, gap_at, gap_v;
    logic [FB-1:0] pend_freq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_commit();
        int ch;
        int best;
        ch = -1;
        if (pend_on) begin
            for (int v = 0; v < NV; v++) if (ch < 0 && m_state[v] != 0 && m_note[v] == pend_note) ch = v;
            for (int v = 0; v < NV; v++) if (ch < 0 && m_state[v] == 0) ch = v;
            for (int cls = 2; cls >= 1; cls--) begin
                if (ch < 0) begin
                    best = -1;
                    for (int v = 0; v < NV; v++)
                        if (m_state[v] == cls && (best < 0 || m_age[v] > m_age[best])) best = v;
                    ch = best;
                end
            end
            m_steal = (m_state[ch] != 0) && (m_note[ch] != pend_note);
            for (int v = 0; v < NV; v++)
                if (v != ch && m_state[v] != 0 && m_age[v] < 255) m_age[v]++;
            if (m_gate[ch]) begin
                m_gate[ch] = 0;
                gap_at     = cyc + GAP;
                gap_v      = ch;
            end else begin
                m_gate[ch] = 1;
                m_ready    = 1;
            end
            m_state[ch] = 1;
            m_note[ch]  = pend_note;
            m_freq[ch]  = pend_freq;
            m_age[ch]   = 0;
        end else begin
            for (int v = 0; v < NV; v++) if (ch < 0 && m_state[v] == 1 && m_note[v] == pend_note) ch = v;
            if (ch >= 0) begin
                m_gate[ch]    = 0;
                m_state[ch]   = 2;
                m_free_at[ch] = cyc + HOLD;
            end
            m_ready = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_ready = 1; m_steal = 0; pend = 0; gap_at = -1; gap_v = 0;
            for (int v = 0; v < NV; v++) begin
                m_state[v] = 0; m_note[v] = 0; m_freq[v] = '0;
                m_age[v] = 0; m_gate[v] = 0; m_free_at[v] = -1;
            end
        end else begin
            m_rdy_prev = m_ready;
            cyc++;
            m_steal = 0;
            for (int v = 0; v < NV; v++)
                if (m_state[v] == 2 && cyc == m_free_at[v]) m_state[v] = 0;
            if (pend && cyc == commit_at) begin
                pend = 0;
                model_commit();
            end
            if (gap_at == cyc) begin
                m_gate[gap_v] = 1;
                m_ready       = 1;
                gap_at        = -1;
            end
            if (m_rdy_prev && bus.ev_valid) begin
                pend      = 1;
                pend_on   = bus.ev_note_on;
                pend_note = int'(bus.ev_note);
                pend_freq = bus.ev_freq;
                commit_at = cyc + NV + 1;
                m_ready   = 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [NV*FB-1:0] ef;
        logic [NV-1:0]    eg, eb;
        for (int v = 0; v < NV; v++) begin
            eg[v]           = m_gate[v];
            eb[v]           = (m_state[v] != 0);
            ef[v*FB +: FB]  = m_freq[v];
        end
        chk("cyc_gate",  64'(bus.voice_gate),  64'(eg));
        chk("cyc_busy",  64'(bus.voice_busy),  64'(eb));
        chk("cyc_freq",  64'(bus.voice_freq),  64'(ef));
        chk("cyc_steal", 64'(bus.steal_pulse), 64'(m_steal));
        chk("cyc_ready", 64'(bus.ev_ready),    64'(m_ready && !rst));
    end

    function automatic logic [FB-1:0] vf(input int i);
        return bus.voice_freq[i*FB +: FB];
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit on, input int note, input logic [FB-1:0] freq);
        int n;
        n = 0;
        while (bus.ev_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", 64'(n < 100), 64'd1);
        bus.ev_valid   = 1'b1;
        bus.ev_note_on = on;
        bus.ev_note    = NB'(note);
        bus.ev_freq    = freq;
        @(negedge clk);
        bus.ev_valid   = 1'b0;
        bus.ev_note_on = ~on;
        bus.ev_note    = 7'h7f;
        bus.ev_freq    = 16'hdead;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ev_valid = 1'b0; bus.ev_note_on = 1'b0; bus.ev_note = '0; bus.ev_freq = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.ev_ready), 64'd0);
        chk("rst_gate",  64'(bus.voice_gate), 64'd0);
        chk("rst_busy",  64'(bus.voice_busy), 64'd0);
        chk("rst_freq",  64'(bus.voice_freq), 64'd0);
        chk("rst_steal", 64'(bus.steal_pulse), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.ev_ready), 64'd1);

        // First note lands on voice0 five edges after accept.
        send(1, 60, 16'h1000);
        wait_n(4);
        chk("t1_gate_e4",  64'(bus.voice_gate), 64'h0);
        chk("t1_ready_e4", 64'(bus.ev_ready), 64'd0);
        wait_n(1);
        chk("t1_gate",  64'(bus.voice_gate), 64'b0001);
        chk("t1_freq0", 64'(vf(0)), 64'h1000);
        chk("t1_ready", 64'(bus.ev_ready), 64'd1);

        send(1, 62, 16'h1100); wait_n(5);
        send(1, 64, 16'h1200); wait_n(5);
        send(1, 65, 16'h1300); wait_n(5);
        chk("t2_gate",  64'(bus.voice_gate), 64'b1111);
        chk("t2_freq3", 64'(vf(3)), 64'h1300);

        // Pool full: oldest active voice0 is stolen and goes through the gap.
        send(1, 67, 16'h1500);
        wait_n(5);
        chk("t3_gate_drop", 64'(bus.voice_gate), 64'b1110);
        chk("t3_steal",     64'(bus.steal_pulse), 64'd1);
        chk("t3_freq0",     64'(vf(0)), 64'h1500);
        chk("t3_ready_gap", 64'(bus.ev_ready), 64'd0);
        wait_n(1);
        chk("t3_steal_end", 64'(bus.steal_pulse), 64'd0);
        wait_n(2);
        chk("t3_gate_e8",   64'(bus.voice_gate), 64'b1110);
        wait_n(1);
        chk("t3_gate_e9",   64'(bus.voice_gate), 64'b1111);
        chk("t3_ready_e9",  64'(bus.ev_ready), 64'd1);

        // Releasing voice1 beats older active voices; no gap needed.
        send(0, 62, 16'h0);
        wait_n(5);
        chk("t4_off_gate", 64'(bus.voice_gate), 64'b1101);
        chk("t4_off_busy", 64'(bus.voice_busy), 64'b1111);
        send(1, 70, 16'h1600);
        wait_n(5);
        chk("t4_gate",  64'(bus.voice_gate), 64'b1111);
        chk("t4_steal", 64'(bus.steal_pulse), 64'd1);
        chk("t4_freq1", 64'(vf(1)), 64'h1600);
        chk("t4_ready", 64'(bus.ev_ready), 64'd1);

        // Unmatched note-off changes nothing.
        send(0, 50, 16'h0);
        wait_n(4);
        chk("t5_ready_e4", 64'(bus.ev_ready), 64'd0);
        wait_n(1);
        chk("t5_gate",  64'(bus.voice_gate), 64'b1111);
        chk("t5_ready", 64'(bus.ev_ready), 64'd1);

        // Release hold: voice0 stays busy for HOLD edges after its gate drops.
        send(0, 67, 16'h0);
        wait_n(5);
        chk("t6_gate",    64'(bus.voice_gate), 64'b1110);
        wait_n(7);
        chk("t6_busy_h7", 64'(bus.voice_busy), 64'b1111);
        wait_n(1);
        chk("t6_busy_h8", 64'(bus.voice_busy), 64'b1110);

        // Same-note retrigger on voice2 wins over free voice0; no steal.
        send(1, 64, 16'h2200);
        wait_n(5);
        chk("t7_gate",  64'(bus.voice_gate), 64'b1010);
        chk("t7_steal", 64'(bus.steal_pulse), 64'd0);
        chk("t7_freq2", 64'(vf(2)), 64'h2200);
        wait_n(4);
        chk("t7_gate_up", 64'(bus.voice_gate), 64'b1110);
        chk("t7_ready",   64'(bus.ev_ready), 64'd1);

        // Reset during scan drops the event and clears everything at once.
        send(1, 72, 16'h3000);
        wait_n(2);
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_gate",  64'(bus.voice_gate), 64'd0);
        chk("t8_rst_busy",  64'(bus.voice_busy), 64'd0);
        chk("t8_rst_freq",  64'(bus.voice_freq), 64'd0);
        chk("t8_rst_ready", 64'(bus.ev_ready), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send(1, 40, 16'h0400);
        wait_n(5);
        chk("t8_gate",  64'(bus.voice_gate), 64'b0001);
        chk("t8_freq0", 64'(vf(0)), 64'h0400);

        wait_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler for the synth core. It accepts a stream of note-on and note-off events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` voice instances. For each voice it drives the frequency word and the envelope gate. When the pool is exhausted it steals a voice, oldest releasing voice first and then oldest active voice. It sits between the MIDI/sequencer front end and the array of voice instances.

## Interface
- `NUM_VOICES`, 4: voice pool size, ≥2.
- `FREQ_BITS`, 16: frequency word width. Matches the voice `tone_freq`.
- `NOTE_BITS`, 7: note number width.
- `AGE_BITS`, 8: per-voice age counter width, saturating.
- `RELEASE_BITS`, 20: release timer width.
- `RELEASE_HOLD`, 1000000: cycles a voice stays "releasing" after its gate drops.
- `RETRIG_GAP`, 4: cycles of forced gate-low before re-gating an already-gated voice. Must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_note_on`  in  1  1 = note-on, 0 = note-off.
- `ev_note`  in  NOTE_BITS  note number.
- `ev_freq`  in  FREQ_BITS  frequency word. Used on note-on only.
- `voice_gate`  out  NUM_VOICES  per-voice envelope gate.
- `voice_freq`  out  NUM_VOICES*FREQ_BITS  per-voice frequency. Voice i occupies bits [i*FREQ_BITS +: FREQ_BITS].
- `voice_busy`  out  NUM_VOICES  voice is active or releasing.
- `steal_pulse`  out  1  one-cycle pulse when a non-free voice is reassigned to a different note.

## Operation
- **Per-voice state:**
  - Slot state: FREE, ACTIVE (gated) or RELEASING.
  - Stored note and frequency.
  - Age counter.
  - Release timer.
- **FSM states:** IDLE, SCAN, COMMIT, GAP.
- **IDLE:**
  - `ev_ready` = 1.
  - On `ev_valid` & `ev_ready`, latch the event, clear the scan index, go to SCAN.
- **SCAN:**
  - Examines one voice per cycle, index 0..NUM_VOICES-1, then goes to COMMIT.
  - Note-on candidate priority:
    1. ACTIVE or RELEASING voice holding the same note (retrigger).
    2. Lowest-index FREE voice.
    3. RELEASING voice with the greatest age.
    4. ACTIVE voice with the greatest age.
  - Age ties resolve to the lowest index.
  - Note-off: selects the lowest-index ACTIVE voice whose note matches.
- **COMMIT, note-on:**
  - Write freq and note; set state ACTIVE; clear the chosen voice's age.
  - Increment the age of every other busy voice, saturating at 2^AGE_BITS-1.
  - If the chosen voice was already gated: drop its gate, load the gap counter with RETRIG_GAP, go to GAP.
  - Otherwise: raise its gate and go to IDLE.
  - Pulse `steal_pulse` if the chosen voice was non-free and its note differs from the event note.
- **COMMIT, note-off:**
  - On a match: drop the gate, set RELEASING, load the release timer with RELEASE_HOLD.
  - With no match: discard the event.
  - Go to IDLE.
- **GAP:**
  - Counter decrements once per cycle.
  - When it reaches 0, raise the gate and go to IDLE.
- **Release timers:**
  - Run every cycle in all FSM states.
  - When the timer reaches 0, RELEASING → FREE.
  - A COMMIT on the same voice in the same cycle wins over expiry.
- A voice that changes state after it has been scanned is not reconsidered. This is deterministic and acceptable.
- `voice_busy[i]` = state ≠ FREE.

## Timing
- **Reset values:**
  - All voices FREE; gate 0; freq 0; age 0; timers 0.
  - `ev_ready` 0 while `rst` is high.
  - FSM IDLE. `ev_ready` is 1 on the first cycle after release.
  - `steal_pulse` 0.
- **Latency, event accepted at edge e0:**
  - SCAN occupies edges e1..eN (N = NUM_VOICES).
  - Outputs update at e(N+1).
  - `ev_ready` is high again after e(N+1) when no gap is needed.
- **Retrigger latency:** the gate is low from e(N+1) and rises at e(N+1+RETRIG_GAP). `ev_ready` stays low throughout.
- **Output registers:** all outputs are registered. Gate, freq and `steal_pulse` change on the same edge.
- **Handshake:** event fields must be stable only in the accept cycle.
- **Reset mid-operation:** the in-flight event is dropped and all state returns to reset values.

## Structure
- **Shared header `voice_alloc_defs.vh`:**
  - FSM state encodings.
  - Slot state encodings (FREE/ACTIVE/RELEASING).
  - Candidate priority class constants.
- **Sub-module `voice_slot`, instantiated NUM_VOICES times:**
  - Holds state, note, freq, age and release timer.
  - Inputs: assign/gate_off/age_inc strobes.
  - Outputs: state, note, freq, gate, age.
- **Top level:** FSM, scan comparator and candidate register.

## Test plan
- Reset, then note-on 60/freq 0x1000 with 4 voices → `voice_gate`=0001 and voice0 freq=0x1000 five cycles after accept; `ev_ready` high the next cycle.
- Four note-ons 60, 62, 64, 65, then a fifth note 67 → voice0 (age 3) stolen. Its gate is low for 4 cycles, then high. Freq = new word; `steal_pulse`=1 for one cycle.
- RELEASE_HOLD=8: note-on 60, note-off 60 → gate drops at commit; `voice_busy[0]` clears 8 cycles later.
- RELEASE_HOLD=8, all 4 voices gated: note-off 62 (voice1), then note-on 70 within 8 cycles → voice1 (releasing) is chosen over older active voices. No gap (gate already low); `steal_pulse`=1.
- Note-off 50 with no matching voice → no output change, `ev_ready` back after 5 cycles.
- Assert `rst` during SCAN → all outputs zero immediately; the next event is allocated to voice0.
